// File: rtl/harris_frame_sequencer.sv
// Harris corner frame sequencer. It drives the datapath en/rst/flush signals and re-tags each
// response with its raster (x,y). A 2-entry queue buffers responses. Option: HARRIS_SEQ_BORDER_MASK_EN.
module harris_frame_sequencer #(
    parameter int unsigned ImageW           = 640,
    parameter int unsigned ImageH           = 480,
    parameter int unsigned outW             = 8,
    parameter int unsigned cornorwindowSize = 5,
    parameter int unsigned latRows          = 3,
    parameter int unsigned latCols          = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      dp_en,
    output logic                      dp_rst,
    output logic                      dp_flush,
    input  logic [outW-1:0]           dp_response,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(ImageW)-1:0] out_x,
    output logic [$clog2(ImageH)-1:0] out_y,
    output logic [outW-1:0]           out_response,
    output logic                      out_eof,
    output logic                      busy
);

    localparam int unsigned Total  = ImageW * ImageH;
    localparam int unsigned LatPix = latRows * ImageW + latCols;
    localparam int unsigned CntW   = $clog2(Total + LatPix + 1);
    localparam int unsigned XW     = $clog2(ImageW);
    localparam int unsigned YW     = $clog2(ImageH);
    localparam int unsigned EW     = XW + YW + outW + 1;
    localparam int unsigned B      = cornorwindowSize / 2 + 1;
`ifdef HARRIS_SEQ_BORDER_MASK_EN
    localparam bit MaskEn = 1'b1;
`else
    localparam bit MaskEn = 1'b0;
`endif

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClr   = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StFlush = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] en_cnt_q, en_cnt_d;
    logic [XW-1:0]   x_cnt_q, x_cnt_d;
    logic [YW-1:0]   y_cnt_q, y_cnt_d;
    logic            cap_pending_q, cap_keep_q, cap_keep_d;
    logic            head_valid_q, head_valid_d, tail_valid_q, tail_valid_d;
    logic [EW-1:0]   head_q, head_d, tail_q, tail_d;

    logic            pop, push, credit_ok, border, eof;
    logic [1:0]      occ, occ_eff;
    logic [outW-1:0] resp_masked;
    logic [EW-1:0]   push_data;

    // Credit uses post-pop occupancy so a steady stream keeps one pixel per cycle.
    always_comb begin
        pop       = head_valid_q & out_ready;
        push      = cap_pending_q & cap_keep_q;
        occ       = {1'b0, head_valid_q} + {1'b0, tail_valid_q};
        occ_eff   = occ - {1'b0, pop};
        credit_ok = (occ_eff + {1'b0, cap_pending_q}) < 2'd2;
    end

    always_comb begin
        border = (32'(x_cnt_q) < B) || (32'(x_cnt_q) >= ImageW - B) ||
                 (32'(y_cnt_q) < B) || (32'(y_cnt_q) >= ImageH - B);
        eof    = (x_cnt_q == XW'(ImageW - 1)) && (y_cnt_q == YW'(ImageH - 1));
        resp_masked = (MaskEn && border) ? '0 : dp_response;
        push_data   = {x_cnt_q, y_cnt_q, resp_masked, eof};
    end

    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        tail_valid_d = tail_valid_q;
        tail_d       = tail_q;
        if (pop) begin
            if (tail_valid_q) begin
                head_d       = tail_q;
                tail_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end
        if (push) begin
            if (!head_valid_d) begin
                head_d       = push_data;
                head_valid_d = 1'b1;
            end else begin
                tail_d       = push_data;
                tail_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        dp_en    = 1'b0;
        case (state_q)
            StIdle: if (frame_start) state_d = StClr;
            StClr:  state_d = StRun;
            StRun: begin
                in_ready = credit_ok;
                dp_en    = in_valid & credit_ok;
                if (dp_en && en_cnt_q == CntW'(Total - 1)) begin
                    state_d = (LatPix == 0) ? StDrain : StFlush;
                end
            end
            StFlush: begin
                dp_en = credit_ok;
                if (dp_en && en_cnt_q == CntW'(Total + LatPix - 1)) state_d = StDrain;
            end
            StDrain: if (!head_valid_d && !tail_valid_d) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_cnt_d   = en_cnt_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        cap_keep_d = en_cnt_q >= CntW'(LatPix);
        if (state_q == StClr) begin
            en_cnt_d = '0;
            x_cnt_d  = '0;
            y_cnt_d  = '0;
        end else begin
            if (dp_en) en_cnt_d = en_cnt_q + CntW'(1);
            if (push) begin
                if (x_cnt_q == XW'(ImageW - 1)) begin
                    x_cnt_d = '0;
                    y_cnt_d = (y_cnt_q == YW'(ImageH - 1)) ? '0 : y_cnt_q + YW'(1);
                end else begin
                    x_cnt_d = x_cnt_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            en_cnt_q      <= '0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            cap_pending_q <= 1'b0;
            cap_keep_q    <= 1'b0;
            head_valid_q  <= 1'b0;
            tail_valid_q  <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q       <= state_d;
            en_cnt_q      <= en_cnt_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            cap_pending_q <= dp_en;
            cap_keep_q    <= cap_keep_d;
            head_valid_q  <= head_valid_d;
            tail_valid_q  <= tail_valid_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    assign {out_x, out_y, out_response, out_eof} = head_q;
    assign out_valid = head_valid_q;
    assign dp_rst    = (state_q == StClr);
    assign dp_flush  = (state_q == StFlush);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Bench for harris_frame_sequencer on an 8x6 frame with LatPix=10. The datapath model echoes
// its enable count, so output k must carry (k+10) mod 256 at raster position k.
module tb_harris_frame_sequencer;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;
    localparam int LP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, dp_en, dp_rst, dp_flush, out_valid, out_eof, busy;
    logic [7:0] dp_response = 8'd0;
    logic [2:0] out_x, out_y;
    logic [7:0] out_response;

    typedef struct {
        int x;
        int y;
        int resp;
        bit eof;
    } rec_t;

    rec_t recs[$];
    int   checks = 0;
    int   failures = 0;
    int   n_in, n_flush, n_dprst, dp_cnt;
    bit   cmode = 1'b0;

    harris_frame_sequencer #(
        .ImageW(W), .ImageH(H), .outW(8), .cornorwindowSize(3), .latRows(1), .latCols(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .in_ready(in_ready), .dp_en(dp_en), .dp_rst(dp_rst), .dp_flush(dp_flush),
        .dp_response(dp_response), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_response(out_response), .out_eof(out_eof),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: response is the number of enables since the last dp_rst.
    always @(posedge clk) begin
        if (dp_rst) dp_cnt <= 0;
        else if (dp_en) begin
            dp_response <= cmode ? 8'h55 : 8'(dp_cnt);
            dp_cnt      <= dp_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready)
                recs.push_back('{x: int'(out_x), y: int'(out_y), resp: int'(out_response),
                                 eof: out_eof});
            if (in_valid && in_ready) n_in = n_in + 1;
            if (dp_en && dp_flush) n_flush = n_flush + 1;
            if (dp_rst) n_dprst = n_dprst + 1;
        end
    end

    function automatic int exp_resp(int k, bit cm);
        int x = k % W;
        int y = k / W;
        int r = cm ? 'h55 : (k + LP) % 256;
`ifdef HARRIS_SEQ_BORDER_MASK_EN
        if (x < 2 || x >= W - 2 || y < 2 || y >= H - 2) r = 0;
`endif
        return r;
    endfunction

    task automatic clear_stats();
        recs.delete();
        n_in = 0;
        n_flush = 0;
        n_dprst = 0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run_until_idle(input bit rnd, output int cycles, output bit to);
        to = 1'b1;
        cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) begin
                to = 1'b0;
                cycles = c;
                break;
            end
            if (rnd) begin
                in_valid    = $urandom_range(0, 1) == 1;
                out_ready   = $urandom_range(0, 1) == 1;
                frame_start = $urandom_range(0, 7) == 0;
            end
        end
        frame_start = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, dp_en, dp_rst, dp_flush, out_valid, out_eof, busy} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {in_ready, dp_en, dp_rst, dp_flush, out_valid, out_eof, busy});
        end
        checks++;
        if ({out_x, out_y, out_response} !== 14'd0) begin
            failures++;
            $display("FAIL reset_data: got x=%0d y=%0d r=%0d expected 0 0 0",
                     out_x, out_y, out_response);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b in_ready=%b expected 0 0",
                     busy, in_ready);
        end
    endtask

    task automatic test_full_frame();
        int  cyc;
        bit  to;
        int  neof = 0;
        cmode = 1'b0;
        clear_stats();
        start_frame();
        checks++;
        if (dp_rst !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_cycle: got dp_rst=%b in_ready=%b expected 1 0", dp_rst, in_ready);
        end
        @(negedge clk);
        checks++;
        if (dp_rst !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_start: got dp_rst=%b in_ready=%b expected 0 1", dp_rst, in_ready);
        end
        run_until_idle(1'b0, cyc, to);
        checks++;
        if (to || cyc > 64) begin
            failures++;
            $display("FAIL full_throughput: got %0d cycles (timeout=%0d) expected <=64", cyc, to);
        end
        checks++;
        if (n_dprst != 1 || n_in != N || n_flush != LP) begin
            failures++;
            $display("FAIL frame_counts: got rst=%0d in=%0d flush=%0d expected 1 %0d %0d",
                     n_dprst, n_in, n_flush, N, LP);
        end
        checks++;
        if (recs.size() != N) begin
            failures++;
            $display("FAIL full_count: got %0d expected %0d", recs.size(), N);
        end
        for (int k = 0; k < recs.size() && k < N; k++) begin
            if (recs[k].eof) neof++;
            checks++;
            if (recs[k].x != k % W || recs[k].y != k / W || recs[k].resp != exp_resp(k, 1'b0) ||
                recs[k].eof != (k == N - 1)) begin
                failures++;
                $display("FAIL full_out[%0d]: got (%0d,%0d) r=%0d eof=%0d expected (%0d,%0d) r=%0d",
                         k, recs[k].x, recs[k].y, recs[k].resp, recs[k].eof, k % W, k / W,
                         exp_resp(k, 1'b0));
            end
        end
        checks++;
        if (neof != 1) begin
            failures++;
            $display("FAIL eof_count: got %0d expected 1", neof);
        end
    endtask

    task automatic test_backpressure();
        int  cyc, nin_mid, x_mid;
        bit  to;
        cmode = 1'b0;
        clear_stats();
        start_frame();
        repeat (15) @(negedge clk);
        out_ready = 1'b0;
        nin_mid = 0;
        x_mid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                nin_mid = n_in;
                x_mid = int'(out_x);
            end
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_state: got in_ready=%b out_valid=%b expected 0 1",
                     in_ready, out_valid);
        end
        checks++;
        if (n_in != nin_mid || int'(out_x) != x_mid) begin
            failures++;
            $display("FAIL hold_stall: got in=%0d x=%0d expected in=%0d x=%0d",
                     n_in, out_x, nin_mid, x_mid);
        end
        out_ready = 1'b1;
        run_until_idle(1'b0, cyc, to);
        checks++;
        if (to || recs.size() != N) begin
            failures++;
            $display("FAIL bp_count: got %0d (timeout=%0d) expected %0d", recs.size(), to, N);
        end
        for (int k = 0; k < recs.size() && k < N; k++) begin
            checks++;
            if (recs[k].x != k % W || recs[k].y != k / W || recs[k].resp != exp_resp(k, 1'b0)) begin
                failures++;
                $display("FAIL bp_out[%0d]: got (%0d,%0d) r=%0d expected (%0d,%0d) r=%0d",
                         k, recs[k].x, recs[k].y, recs[k].resp, k % W, k / W, exp_resp(k, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        bit  to;
        cmode = 1'b0;
        for (int f = 0; f < 3; f++) begin
            clear_stats();
            start_frame();
            run_until_idle(1'b1, cyc, to);
            checks++;
            if (to || recs.size() != N || n_dprst != 1) begin
                failures++;
                $display("FAIL rand_frame%0d: got outs=%0d rst=%0d timeout=%0d expected %0d 1 0",
                         f, recs.size(), n_dprst, to, N);
            end
            for (int k = 0; k < recs.size() && k < N; k++) begin
                checks++;
                if (recs[k].x != k % W || recs[k].y != k / W ||
                    recs[k].resp != exp_resp(k, 1'b0) || recs[k].eof != (k == N - 1)) begin
                    failures++;
                    $display("FAIL rand_out%0d[%0d]: got (%0d,%0d) r=%0d expected (%0d,%0d) r=%0d",
                             f, k, recs[k].x, recs[k].y, recs[k].resp, k % W, k / W,
                             exp_resp(k, 1'b0));
                end
            end
        end
    endtask

    task automatic test_border_mask();
        int  cyc;
        bit  to;
        int  pts[4][2];
        pts[0] = '{1, 3};
        pts[1] = '{6, 2};
        pts[2] = '{2, 2};
        pts[3] = '{5, 3};
        cmode = 1'b1;
        clear_stats();
        start_frame();
        run_until_idle(1'b0, cyc, to);
        checks++;
        if (to || recs.size() != N) begin
            failures++;
            $display("FAIL mask_count: got %0d (timeout=%0d) expected %0d", recs.size(), to, N);
        end
        for (int p = 0; p < 4; p++) begin
            int k = pts[p][1] * W + pts[p][0];
            if (k < recs.size()) begin
                checks++;
                if (recs[k].x != pts[p][0] || recs[k].y != pts[p][1] ||
                    recs[k].resp != exp_resp(k, 1'b1)) begin
                    failures++;
                    $display("FAIL mask_pt(%0d,%0d): got (%0d,%0d) r=%0d expected r=%0d",
                             pts[p][0], pts[p][1], recs[k].x, recs[k].y, recs[k].resp,
                             exp_resp(k, 1'b1));
                end
            end
        end
        cmode = 1'b0;
    endtask

    task automatic test_reset_in_flush();
        int  cyc;
        bit  to;
        bit  seen = 1'b0;
        cmode = 1'b0;
        clear_stats();
        start_frame();
        for (int c = 0; c < 200; c++) begin
            if (dp_flush) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL flush_reached: got 0 expected 1");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || dp_flush !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush: got busy=%b ov=%b ir=%b fl=%b expected 0 0 0 0",
                     busy, out_valid, in_ready, dp_flush);
        end
        clear_stats();
        start_frame();
        run_until_idle(1'b0, cyc, to);
        checks++;
        if (to || recs.size() != N) begin
            failures++;
            $display("FAIL post_rst_count: got %0d (timeout=%0d) expected %0d",
                     recs.size(), to, N);
        end
        for (int k = 0; k < recs.size() && k < N; k++) begin
            checks++;
            if (recs[k].x != k % W || recs[k].y != k / W || recs[k].resp != exp_resp(k, 1'b0)) begin
                failures++;
                $display("FAIL post_rst_out[%0d]: got (%0d,%0d) r=%0d expected (%0d,%0d) r=%0d",
                         k, recs[k].x, recs[k].y, recs[k].resp, k % W, k / W, exp_resp(k, 1'b0));
            end
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_full_frame();
        test_backpressure();
        test_back_to_back();
        test_border_mask();
        test_reset_in_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
